// File: rtl/branch_predict_resolve_pkg.sv
// Shared pipeline definitions for branch prediction: 2-bit counter
// encodings and the instruction byte stride.
package branch_predict_resolve_pkg;

    typedef enum logic [1:0] {
        SNT = 2'b00,
        WNT = 2'b01,
        WT  = 2'b10,
        ST  = 2'b11
    } ctr_t;

    localparam ctr_t RESET_CTR   = WNT;
    localparam ctr_t ALLOC_CTR   = WT;
    localparam int   INSTR_BYTES = 4;

endpackage

// File: rtl/branch_predict_resolve_sat_counter2.sv
// Next-state function of a 2-bit saturating up/down counter.
module sat_counter2
    import branch_predict_resolve_pkg::*;
(
    input  ctr_t cur,
    input  logic up,
    output ctr_t nxt
);

    always_comb begin
        nxt = cur;
        if (up) begin
            if (cur != ST) nxt = ctr_t'(cur + 2'd1);
        end else begin
            if (cur != SNT) nxt = ctr_t'(cur - 2'd1);
        end
    end

endmodule

// File: rtl/branch_predict_resolve.sv
// Direct-mapped BTB with 2-bit counters: combinational fetch lookup,
// EX-stage resolution, training, flush/redirect and mispredict statistics.
module branch_predict_resolve
    import branch_predict_resolve_pkg::*;
#(
    parameter int ADDRESS_WIDTH = 32,
    parameter int INDEX_WIDTH   = 6,
    parameter int COUNT_WIDTH   = 16
) (
    input  logic                     i_Clk,
    input  logic                     i_Reset_n,
    input  logic                     i_Stall,
    input  logic [ADDRESS_WIDTH-1:0] i_Fetch_PC,
    output logic                     o_Prediction,
    output logic [ADDRESS_WIDTH-1:0] o_Pred_Target,
    input  logic                     i_Ex_Is_Branch,
    input  logic [ADDRESS_WIDTH-1:0] i_Ex_PC,
    input  logic                     i_Ex_Taken,
    input  logic [ADDRESS_WIDTH-1:0] i_Ex_Target,
    input  logic                     i_Ex_Prediction,
    output logic                     o_Flush,
    output logic [ADDRESS_WIDTH-1:0] o_Redirect_PC,
    output logic [COUNT_WIDTH-1:0]   o_Mispredict_Count
);

    localparam int ENTRIES = 1 << INDEX_WIDTH;
    localparam int TAG_W   = ADDRESS_WIDTH - INDEX_WIDTH - 2;

    logic               tbl_valid  [ENTRIES];
    ctr_t               tbl_ctr    [ENTRIES];
    logic [TAG_W-1:0]   tbl_tag    [ENTRIES];
    logic [ADDRESS_WIDTH-1:0] tbl_target [ENTRIES];

    logic [INDEX_WIDTH-1:0] fetch_idx, ex_idx;
    logic [TAG_W-1:0]       fetch_tag, ex_tag;
    logic                   fetch_hit, ex_hit;
    logic                   res, mis;
    ctr_t                   ex_ctr_nxt;
    logic                   unused_fetch_bits;

    assign fetch_idx = i_Fetch_PC[INDEX_WIDTH+1:2];
    assign fetch_tag = i_Fetch_PC[ADDRESS_WIDTH-1:INDEX_WIDTH+2];
    assign ex_idx    = i_Ex_PC[INDEX_WIDTH+1:2];
    assign ex_tag    = i_Ex_PC[ADDRESS_WIDTH-1:INDEX_WIDTH+2];
    assign unused_fetch_bits = ^i_Fetch_PC[1:0];

    // Lookup reads the registered table, so a same-cycle update is not seen.
    assign fetch_hit     = tbl_valid[fetch_idx] && (tbl_tag[fetch_idx] == fetch_tag);
    assign o_Prediction  = fetch_hit && tbl_ctr[fetch_idx][1];
    assign o_Pred_Target = o_Prediction ? tbl_target[fetch_idx] : '0;

    // A stalled EX instruction is held, so it must act only once it moves.
    assign res     = i_Ex_Is_Branch && !i_Stall;
    assign mis     = res && (i_Ex_Prediction != i_Ex_Taken);
    assign ex_hit  = tbl_valid[ex_idx] && (tbl_tag[ex_idx] == ex_tag);
    assign o_Flush = mis;

    always_comb begin
        o_Redirect_PC = '0;
        if (mis) begin
            o_Redirect_PC = i_Ex_Taken ? i_Ex_Target
                                       : i_Ex_PC + ADDRESS_WIDTH'(INSTR_BYTES);
        end
    end

    sat_counter2 u_sat_counter2 (
        .cur (tbl_ctr[ex_idx]),
        .up  (i_Ex_Taken),
        .nxt (ex_ctr_nxt)
    );

    always_ff @(posedge i_Clk or negedge i_Reset_n) begin
        if (!i_Reset_n) begin
            for (int i = 0; i < ENTRIES; i++) begin
                tbl_valid[i]  <= 1'b0;
                tbl_ctr[i]    <= RESET_CTR;
                tbl_tag[i]    <= '0;
                tbl_target[i] <= '0;
            end
        end else if (res) begin
            if (ex_hit) begin
                tbl_ctr[ex_idx] <= ex_ctr_nxt;
                if (i_Ex_Taken) tbl_target[ex_idx] <= i_Ex_Target;
            end else if (i_Ex_Taken) begin
                tbl_valid[ex_idx]  <= 1'b1;
                tbl_tag[ex_idx]    <= ex_tag;
                tbl_target[ex_idx] <= i_Ex_Target;
                tbl_ctr[ex_idx]    <= ALLOC_CTR;
            end
        end
    end

    always_ff @(posedge i_Clk or negedge i_Reset_n) begin
        if (!i_Reset_n) begin
            o_Mispredict_Count <= '0;
        end else if (mis && (o_Mispredict_Count != '1)) begin
            o_Mispredict_Count <= o_Mispredict_Count + 1'b1;
        end
    end

endmodule

// File: tb/tb_branch_predict_resolve.sv
// Directed bench for branch_predict_resolve: driver pushes expected outputs,
// a negedge monitor pops and compares them against the live DUT outputs.
module tb_branch_predict_resolve;

  localparam int W = 32;

  localparam int SEL_PRED   = 0;
  localparam int SEL_TARGET = 1;
  localparam int SEL_FLUSH  = 2;
  localparam int SEL_REDIR  = 3;
  localparam int SEL_COUNT  = 4;

  logic          i_Clk = 1'b0;
  logic          i_Reset_n = 1'b0;
  logic          i_Stall = 1'b0;
  logic [W-1:0]  i_Fetch_PC = '0;
  logic          o_Prediction;
  logic [W-1:0]  o_Pred_Target;
  logic          i_Ex_Is_Branch = 1'b0;
  logic [W-1:0]  i_Ex_PC = '0;
  logic          i_Ex_Taken = 1'b0;
  logic [W-1:0]  i_Ex_Target = '0;
  logic          i_Ex_Prediction = 1'b0;
  logic          o_Flush;
  logic [W-1:0]  o_Redirect_PC;
  logic [15:0]   o_Mispredict_Count;

  logic [W-1:0]  exp_q[$];
  int            sel_q[$];
  string         name_q[$];
  int            pass_cnt = 0;
  int            total_cnt = 0;

  branch_predict_resolve dut (
    .i_Clk              (i_Clk),
    .i_Reset_n          (i_Reset_n),
    .i_Stall            (i_Stall),
    .i_Fetch_PC         (i_Fetch_PC),
    .o_Prediction       (o_Prediction),
    .o_Pred_Target      (o_Pred_Target),
    .i_Ex_Is_Branch     (i_Ex_Is_Branch),
    .i_Ex_PC            (i_Ex_PC),
    .i_Ex_Taken         (i_Ex_Taken),
    .i_Ex_Target        (i_Ex_Target),
    .i_Ex_Prediction    (i_Ex_Prediction),
    .o_Flush            (o_Flush),
    .o_Redirect_PC      (o_Redirect_PC),
    .o_Mispredict_Count (o_Mispredict_Count)
  );

  // clock / watchdog
  always #5 i_Clk = ~i_Clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, got no end, want finish");
    $fatal(1, "watchdog");
  end

  // driver tasks
  task automatic step();
    @(posedge i_Clk);
    #1;
  endtask

  task automatic expect_out(input string name, input int sel, input logic [W-1:0] val);
    name_q.push_back(name);
    sel_q.push_back(sel);
    exp_q.push_back(val);
  endtask

  task automatic ex_drive(input logic br, input logic [W-1:0] pc, input logic taken,
                          input logic [W-1:0] tgt, input logic pred);
    i_Ex_Is_Branch  = br;
    i_Ex_PC         = pc;
    i_Ex_Taken      = taken;
    i_Ex_Target     = tgt;
    i_Ex_Prediction = pred;
  endtask

  task automatic ex_idle();
    ex_drive(1'b0, '0, 1'b0, '0, 1'b0);
  endtask

  task automatic expect_lookup(input string name, input logic [W-1:0] pc,
                               input logic pred, input logic [W-1:0] tgt);
    i_Fetch_PC = pc;
    expect_out({name, "_pred"}, SEL_PRED, W'(pred));
    expect_out({name, "_tgt"}, SEL_TARGET, tgt);
  endtask

  task automatic expect_resolve(input string name, input logic flush, input logic [W-1:0] redir);
    expect_out({name, "_flush"}, SEL_FLUSH, W'(flush));
    expect_out({name, "_redir"}, SEL_REDIR, redir);
  endtask

  // scoreboard monitor
  always @(negedge i_Clk) begin
    while (exp_q.size() > 0) begin
      automatic logic [W-1:0] want = exp_q.pop_front();
      automatic int           sel  = sel_q.pop_front();
      automatic string        nm   = name_q.pop_front();
      automatic logic [W-1:0] got;
      case (sel)
        SEL_PRED:   got = W'(o_Prediction);
        SEL_TARGET: got = o_Pred_Target;
        SEL_FLUSH:  got = W'(o_Flush);
        SEL_REDIR:  got = o_Redirect_PC;
        default:    got = W'(o_Mispredict_Count);
      endcase
      total_cnt++;
      if (got === want) pass_cnt++;
      else $display("FAIL %s: got 0x%08h want 0x%08h", nm, got, want);
    end
  end

  initial begin
    ex_idle();
    step();
    step();
    i_Reset_n = 1'b1;

    // reset state
    expect_lookup("rst_lookup", 32'h0040_0100, 1'b0, 32'h0);
    expect_out("rst_count", SEL_COUNT, 32'd0);
    expect_resolve("rst_idle", 1'b0, 32'h0);
    step();

    // miss, taken, predicted not-taken: allocate + flush; lookup is pre-update
    ex_drive(1'b1, 32'h0040_0100, 1'b1, 32'h0040_0200, 1'b0);
    expect_resolve("alloc", 1'b1, 32'h0040_0200);
    expect_lookup("alloc_rbw", 32'h0040_0100, 1'b0, 32'h0);
    expect_out("alloc_count_pre", SEL_COUNT, 32'd0);
    step();
    ex_idle();
    expect_lookup("alloc_after", 32'h0040_0100, 1'b1, 32'h0040_0200);
    expect_out("alloc_count", SEL_COUNT, 32'd1);
    step();

    // WT -> WNT with mispredict, then WNT -> SNT correctly predicted
    ex_drive(1'b1, 32'h0040_0100, 1'b0, 32'h0, 1'b1);
    expect_resolve("nt1", 1'b1, 32'h0040_0104);
    step();
    ex_idle();
    expect_lookup("nt1_after", 32'h0040_0100, 1'b0, 32'h0);
    step();
    ex_drive(1'b1, 32'h0040_0100, 1'b0, 32'h0, 1'b0);
    expect_resolve("nt2", 1'b0, 32'h0);
    step();
    ex_idle();
    expect_lookup("nt2_after", 32'h0040_0100, 1'b0, 32'h0);
    expect_out("nt2_count", SEL_COUNT, 32'd2);
    step();

    // stalled mispredict: no action for 3 cycles, then exactly one
    ex_drive(1'b1, 32'h0040_0100, 1'b1, 32'h0040_0200, 1'b0);
    i_Stall = 1'b1;
    for (int c = 0; c < 3; c++) begin
      expect_resolve("stall", 1'b0, 32'h0);
      expect_out("stall_count", SEL_COUNT, 32'd2);
      expect_lookup("stall_lookup", 32'h0040_0100, 1'b0, 32'h0);
      step();
    end
    i_Stall = 1'b0;
    #1;
    total_cnt++;
    if (o_Flush === 1'b1 && o_Mispredict_Count === 16'd2) pass_cnt++;
    else $display("FAIL unstall_now: got flush=%0b count=%0d want flush=1 count=2",
                  o_Flush, o_Mispredict_Count);
    expect_resolve("unstall", 1'b1, 32'h0040_0200);
    step();
    ex_idle();
    // SNT +1 -> WNT: still not-taken, which also proves the stall cycles trained nothing
    expect_lookup("unstall_after", 32'h0040_0100, 1'b0, 32'h0);
    expect_out("unstall_count", SEL_COUNT, 32'd3);
    step();

    // aliasing on index 0: new tag replaces the entry
    ex_drive(1'b1, 32'h0000_0100, 1'b1, 32'h0000_0300, 1'b1);
    expect_resolve("alias_a", 1'b0, 32'h0);
    step();
    ex_idle();
    expect_lookup("alias_a_after", 32'h0000_0100, 1'b1, 32'h0000_0300);
    step();
    ex_drive(1'b1, 32'h0001_0100, 1'b1, 32'h0000_0500, 1'b1);
    step();
    ex_idle();
    expect_lookup("alias_old", 32'h0000_0100, 1'b0, 32'h0);
    step();
    expect_lookup("alias_new", 32'h0001_0100, 1'b1, 32'h0000_0500);
    step();

    // fall-through redirect wraps at the top of the address space
    ex_drive(1'b1, 32'hFFFF_FFFC, 1'b0, 32'h0, 1'b1);
    expect_resolve("wrap", 1'b1, 32'h0000_0000);
    step();
    ex_idle();
    expect_out("wrap_count", SEL_COUNT, 32'd4);
    step();

    // asynchronous reset mid-run clears table and count without a clock edge
    i_Fetch_PC = 32'h0001_0100;
    i_Reset_n  = 1'b0;
    #1;
    total_cnt++;
    if (o_Mispredict_Count === 16'd0) pass_cnt++;
    else $display("FAIL midrst_count_now: got %0d want 0", o_Mispredict_Count);
    total_cnt++;
    if (o_Prediction === 1'b0 && o_Pred_Target === 32'h0) pass_cnt++;
    else $display("FAIL midrst_lookup_now: got pred=%0b tgt=0x%08h want pred=0 tgt=0",
                  o_Prediction, o_Pred_Target);
    expect_lookup("midrst", 32'h0001_0100, 1'b0, 32'h0);
    expect_out("midrst_count", SEL_COUNT, 32'd0);
    step();
    i_Reset_n = 1'b1;
    expect_lookup("postrst", 32'h0001_0100, 1'b0, 32'h0);
    expect_lookup("postrst_a", 32'h0040_0100, 1'b0, 32'h0);
    step();

    @(negedge i_Clk);
    #1;
    if (exp_q.size() != 0)
      $display("FAIL drain: got %0d pending expectations want 0", exp_q.size());
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    if (pass_cnt == total_cnt && exp_q.size() == 0) $display("PASS");
    else $display("FAIL");
    $finish;
  end

endmodule

// File: doc/branch_predict_resolve.md
Name: branch_predict_resolve

Overview:
- Produces the per-instruction prediction bit carried down the pipe with each instruction, from a direct-mapped BTB that holds 2-bit saturating counters.
- Consumes that same bit when the branch reaches EX.
- On resolution it trains the table, detects a mispredict, and drives the pipeline flush and fetch-redirect.
- Fetch-side lookup is combinational. Table update is on the clock edge.

Parameters:
- ADDRESS_WIDTH, 32, PC/target width.
- INDEX_WIDTH, 6, log2 of BTB entries (64).
- COUNT_WIDTH, 16, width of the saturating mispredict statistics counter.

Ports:
- i_Clk  in  1  clock
- i_Reset_n  in  1  async reset, active-low
- i_Stall  in  1  pipeline stall; EX instruction is held
- i_Fetch_PC  in  ADDRESS_WIDTH  PC being fetched this cycle
- o_Prediction  out  1  predicted taken for i_Fetch_PC
- o_Pred_Target  out  ADDRESS_WIDTH  predicted target; 0 when o_Prediction=0
- i_Ex_Is_Branch  in  1  EX-stage instruction is a conditional branch
- i_Ex_PC  in  ADDRESS_WIDTH  PC of the EX instruction
- i_Ex_Taken  in  1  resolved direction
- i_Ex_Target  in  ADDRESS_WIDTH  resolved taken target
- i_Ex_Prediction  in  1  prediction bit piped with the instruction
- o_Flush  out  1  mispredict; flush younger stages
- o_Redirect_PC  out  ADDRESS_WIDTH  correct next PC when o_Flush=1, else 0
- o_Mispredict_Count  out  COUNT_WIDTH  saturating mispredict total

Behaviour:
- Reset is i_Reset_n, asynchronous, active-low; clock is i_Clk.
- Reset state:
  - All entry valid bits 0.
  - Counters 2'b01 (weakly not-taken).
  - Tags and targets 0.
  - o_Mispredict_Count 0.
- The combinational outputs follow from the reset table state: o_Prediction=0 and o_Pred_Target=0 for any PC.
- Reset asserted mid-operation clears the whole table immediately, including any in-flight update.
- Address split:
  - index = PC[INDEX_WIDTH+1:2]
  - tag = PC[ADDRESS_WIDTH-1:INDEX_WIDTH+2]
  - PC[1:0] is ignored.
- Lookup (0-cycle, combinational):
  - hit = valid[index] && tag match.
  - o_Prediction = hit && counter[1].
  - o_Pred_Target = o_Prediction ? target : 0.
- Resolve qualifier: res = i_Ex_Is_Branch && !i_Stall. Nothing trains, flushes or counts while stalled, so a held instruction acts exactly once.
- Mispredict: mis = res && (i_Ex_Prediction != i_Ex_Taken).
- o_Flush = mis (combinational, same cycle as EX).
- o_Redirect_PC when mis:
  - i_Ex_Taken=1: i_Ex_Target.
  - i_Ex_Taken=0: i_Ex_PC+4, modulo 2^ADDRESS_WIDTH, wraps.
  - Otherwise 0.
- Update at posedge when res:
  - Hit, taken: counter saturating increment (max 2'b11); target overwritten with i_Ex_Target.
  - Hit, not taken: counter saturating decrement (min 2'b00).
  - Miss, taken: allocate. valid=1, tag=Ex tag, target=i_Ex_Target, counter=2'b10 (replaces any aliasing entry).
  - Miss, not taken: no change.
- Hit/miss for the update is evaluated on i_Ex_PC, independent of i_Ex_Prediction.
- Simultaneous fetch lookup and update to the same index: lookup returns pre-update contents (read-before-write). The new value is visible the next cycle.
- o_Mispredict_Count increments by 1 at each posedge where mis=1 and saturates at all-ones.
- No internal FSM beyond the per-entry 2-bit counters.
- Stall does not affect lookup.

Decomposition:
- Shared package (pipeline package):
  - Counter encodings: SNT=2'b00, WNT=2'b01, WT=2'b10, ST=2'b11.
  - Reset counter value WNT.
  - Allocate counter value WT.
  - Instruction byte offset constant 4.
- Sub-module sat_counter2: 2-bit saturating up/down next-state function.
- Table storage and the resolve logic stay in the top module.

Test Plan:
- Reset, then i_Fetch_PC=0x0040_0100 -> o_Prediction=0, o_Pred_Target=0; o_Mispredict_Count=0.
- EX branch PC=0x0040_0100, taken, target=0x0040_0200, Ex_Prediction=0 -> o_Flush=1, o_Redirect_PC=0x0040_0200, count=1. Next cycle fetch 0x0040_0100 -> o_Prediction=1, o_Pred_Target=0x0040_0200.
- Same branch resolved not-taken twice with Ex_Prediction=1 then 0:
  - First resolve: o_Flush=1, o_Redirect_PC=0x0040_0104.
  - Second resolve: o_Flush=0.
  - Counter then 00, so lookup prediction=0.
- i_Stall=1 for 3 cycles with a mispredicting EX branch -> o_Flush=0, no table or count change. After stall drops: one o_Flush pulse, count +1 only.
- Aliasing: PC=0x0000_0100 allocated, then taken branch at 0x0001_0100 (same index, new tag) -> entry replaced. Lookup 0x0000_0100 -> prediction=0.
- i_Ex_PC=0xFFFF_FFFC, not taken, Ex_Prediction=1 -> o_Redirect_PC=0x0000_0000.
- Assert reset mid-run after training -> all lookups predict 0 and count=0 immediately.
